// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, valid/ready in, registered tx out.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int CLK_PER_BAUD = 1,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]           parity_mode,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BAUD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_on;
  logic                 par_bit;
`endif

  assign tx_ready = (state == S_IDLE) & ~rst;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_STOP) &
                    (stop_cnt == STOP_LAST) &
                    bit_end;

  // Frame sequencer: tx is loaded with the next bit value on each boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_on   <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          tx       <= 1'b1;
          if (accept) begin
            shreg <= tx_data;
            state <= S_START;
            tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_on  <= (parity_mode == 2'b01) |
                       (parity_mode == 2'b10);
            par_bit <= (^tx_data) ^
                       (parity_mode == 2'b10);
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_on) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              state    <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three UART configurations checked against a bit-list model.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  logic [8:0] data [3];
  logic [1:0] pm [3];
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] txo;
  logic [2:0] busy;
  logic [2:0] done;

  int vectors = 0;
  int errors  = 0;

  int cpb [3] = '{4, 3, 1};
  int db  [3] = '{8, 7, 8};
  int sb  [3] = '{1, 2, 1};

  // Free-running bench clock
  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_PER_BAUD(4), .DATA_BITS(8), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .tx_data(data[0][7:0]),
    .tx_valid(valid[0]),
    .tx_ready(ready[0]),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pm[0]),
`endif
    .tx(txo[0]), .busy(busy[0]), .done(done[0])
  );

  uart_tx_frame #(
    .CLK_PER_BAUD(3), .DATA_BITS(7), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .tx_data(data[1][6:0]),
    .tx_valid(valid[1]),
    .tx_ready(ready[1]),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pm[1]),
`endif
    .tx(txo[1]), .busy(busy[1]), .done(done[1])
  );

  uart_tx_frame #(
    .CLK_PER_BAUD(1), .DATA_BITS(8), .STOP_BITS(1)
  ) dut_c (
    .clk(clk), .rst(rst),
    .tx_data(data[2][7:0]),
    .tx_valid(valid[2]),
    .tx_ready(ready[2]),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pm[2]),
`endif
    .tx(txo[2]), .busy(busy[2]), .done(done[2])
  );

  function automatic bit par_active(input logic [1:0] m);
    bit pa;
    pa = 1'b0;
`ifdef UART_TX_PARITY_EN
    pa = (m == 2'b01) || (m == 2'b10);
`endif
    return pa;
  endfunction

  function automatic int frame_bits(input int k, input logic [1:0] m);
    return 1 + db[k] + int'(par_active(m)) + sb[k];
  endfunction

  function automatic logic exp_bit(input int k, input logic [8:0] w,
                                   input logic [1:0] m, input int b);
    logic p;
    p = (m == 2'b10);
    for (int j = 0; j < db[k]; j++) p = p ^ w[j];
    if (b == 0) return 1'b0;
    if (b <= db[k]) return w[b-1];
    if (par_active(m) && b == db[k] + 1) return p;
    return 1'b1;
  endfunction

  task automatic run_frame(input int k, input bit toggle,
                           input bit keep, input logic [8:0] nxt);
    logic [8:0] w;
    logic [1:0] m;
    int n, c, t;
    t = 0;
    while (ready[k] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait dut%0d: tx_ready=%b required 1",
               k, ready[k]);
      valid[k] = 1'b0;
      return;
    end
    w = data[k];
    m = pm[k];
    c = cpb[k];
    n = frame_bits(k, m) * c;
    @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      vectors += 4;
      if (txo[k] !== exp_bit(k, w, m, (i - 1) / c)) begin
        errors++;
        $display("FAIL tx dut%0d word %h cyc %0d: got %b want %b",
                 k, w, i, txo[k], exp_bit(k, w, m, (i - 1) / c));
      end
      if (busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL busy dut%0d cyc %0d: got %b want 1",
                 k, i, busy[k]);
      end
      if (ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy dut%0d cyc %0d: got %b want 0",
                 k, i, ready[k]);
      end
      if (done[k] !== (i == n)) begin
        errors++;
        $display("FAIL done dut%0d cyc %0d: got %b want %b",
                 k, i, done[k], (i == n));
      end
      if (keep) begin
        valid[k] = 1'b1;
        data[k]  = nxt;
      end else if (toggle) begin
        valid[k] = 1'($urandom_range(0, 1));
        data[k]  = 9'($urandom);
      end else begin
        valid[k] = 1'b0;
      end
    end
    @(negedge clk);
    vectors += 4;
    if (txo[k] !== 1'b1) begin
      errors++;
      $display("FAIL idle_tx dut%0d: got %b want 1", k, txo[k]);
    end
    if (busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy dut%0d: got %b want 0", k, busy[k]);
    end
    if (done[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle_done dut%0d: got %b want 0", k, done[k]);
    end
    if (ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready dut%0d: got %b want 1", k, ready[k]);
    end
    if (!keep) valid[k] = 1'b0;
  endtask

  task automatic start_word(input int k, input logic [8:0] w,
                            input logic [1:0] m);
    data[k]  = w;
    pm[k]    = m;
    valid[k] = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      data[k] = '0;
      pm[k]   = 2'b00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors += 4;
      if (txo[k] !== 1'b1) begin
        errors++;
        $display("FAIL rst_tx dut%0d: got %b want 1", k, txo[k]);
      end
      if (busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy dut%0d: got %b want 0", k, busy[k]);
      end
      if (done[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_done dut%0d: got %b want 0", k, done[k]);
      end
      if (ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_ready dut%0d: got %b want 0", k, ready[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_word(0, 9'h0A5, 2'b00);
    run_frame(0, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_back_to_back();
    start_word(0, 9'h000, 2'b00);
    run_frame(0, 1'b0, 1'b1, 9'h0FF);
    run_frame(0, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_parity();
    start_word(0, 9'h007, 2'b01);
    run_frame(0, 1'b0, 1'b0, 9'h000);
    start_word(0, 9'h007, 2'b10);
    run_frame(0, 1'b0, 1'b0, 9'h000);
    start_word(0, 9'h007, 2'b11);
    run_frame(0, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_stop2();
    start_word(1, 9'h055, 2'b00);
    run_frame(1, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_cpb1();
    start_word(2, 9'h0C3, 2'b01);
    run_frame(2, 1'b0, 1'b1, 9'h01E);
    run_frame(2, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_reset_mid();
    start_word(0, 9'h05A, 2'b00);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (3 * cpb[0]) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", busy[0]);
    end
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      vectors += 4;
      if (txo[0] !== 1'b1) begin
        errors++;
        $display("FAIL mid_rst_tx: got %b want 1", txo[0]);
      end
      if (busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_busy: got %b want 0", busy[0]);
      end
      if (ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_ready: got %b want 0", ready[0]);
      end
      if (done[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_done: got %b want 0", done[0]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    start_word(0, 9'h03C, 2'b00);
    run_frame(0, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_toggle();
    for (int r = 0; r < 3; r++) begin
      start_word(0, 9'($urandom), 2'($urandom_range(0, 3)));
      run_frame(0, 1'b1, 1'b0, 9'h000);
    end
  endtask

  task automatic test_random();
    int k;
    bit keep;
    k = 0;
    for (int r = 0; r < 12; r++) begin
      if (!keep || r == 0) begin
        k = r % 3;
        start_word(k, 9'($urandom), 2'($urandom_range(0, 3)));
      end
      keep = (r != 11) && ($urandom_range(0, 1) == 1);
      pm[k] = 2'($urandom_range(0, 3));
      run_frame(k, 1'b0, keep, 9'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_cpb1();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
